// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC and the instruction register, stalls
// the core while the instruction memory is not ready, and decodes the IR
// into its register and function fields.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  inst_sel,
  input  logic [31:0] alu_result,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] ir,
  output logic        hold,
  output logic        illegal,
  output logic        misalign_err,
  output logic [31:0] instret
);

  localparam logic [1:0] PC_P4  = 2'd0;
  localparam logic [1:0] PC_ALU = 2'd1;
  localparam logic [1:0] PC_OLD = 2'd2;
  localparam logic [1:0] PC_M4  = 2'd3;

  localparam logic [1:0] INST_MEM = 2'd0;
  localparam logic [1:0] INST_NOP = 2'd1;

  logic [31:0] pc_next;

  // Stall only when we actually want a memory word and it is not there yet;
  // reset does not mask this, the core sees the raw memory handshake.
  always_comb begin
    hold = (inst_sel == INST_MEM) && !imem_ready;
  end

  // Next-PC mux; arithmetic wraps naturally at 32 bits.
  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_P4:   pc_next = pc + 32'd4;
      PC_ALU:  pc_next = {alu_result[31:2], 2'b00};
      PC_OLD:  pc_next = pc;
      PC_M4:   pc_next = pc - 32'd4;
      default: pc_next = pc;
    endcase
  end

  // PC, IR, retire counter and sticky misalignment flag; PC and IR move on the
  // same edge so IR always holds the word fetched from the previous PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      ir           <= NOP_INST;
      instret      <= 32'd0;
      misalign_err <= 1'b0;
    end else if (!hold) begin
      pc <= pc_next;
      case (inst_sel)
        INST_MEM: ir <= imem_rdata;
        INST_NOP: ir <= NOP_INST;
        default:  ir <= ir;
      endcase
      if (inst_sel == INST_MEM)
        instret <= instret + 32'd1;
      if ((pc_sel == PC_ALU) && (alu_result[1:0] != 2'b00))
        misalign_err <= 1'b1;
    end
  end

  // Register-only decode and address outputs.
  always_comb begin
    imem_addr = pc;
    pc_plus4  = pc + 32'd4;
    opcode    = ir[6:2];
    func3     = ir[14:12];
    func7     = ir[31:25];
    rd        = ir[11:7];
    rs1       = ir[19:15];
    rs2       = ir[24:20];
    illegal   = (ir[1:0] != 2'b11);
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, sequential fetch, stalls, jumps,
// select combinations, PC wrap and reset during a stall.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [1:0]  inst_sel;
  logic [31:0] alu_result;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] imem_addr, pc, pc_plus4, ir, instret;
  logic [4:0]  opcode, rd, rs1, rs2;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        hold, illegal, misalign_err;

  int checks = 0;
  int errors = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .inst_sel(inst_sel),
    .alu_result(alu_result), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4), .opcode(opcode),
    .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2), .ir(ir),
    .hold(hold), .illegal(illegal), .misalign_err(misalign_err), .instret(instret)
  );

  always #5 clk = ~clk;

  // advance one rising edge, return 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_sel = 2'd0; inst_sel = 2'd0; alu_result = 32'd0;
    imem_rdata = 32'd0; imem_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (ir !== 32'h13) begin errors++; $display("FAIL reset_ir got %h want %h", ir, 32'h13); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
    checks++; if (opcode !== 5'b00100) begin errors++; $display("FAIL reset_opcode got %b want 00100", opcode); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h want 4", pc_plus4); end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_pc;
    do_reset();
    pc_sel = 2'd0; inst_sel = 2'd0; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, exp_pc); end
    end
    checks++; if (ir !== 32'h0050_0093) begin errors++; $display("FAIL seq_ir got %h want 00500093", ir); end
    checks++; if (opcode !== 5'b00100) begin errors++; $display("FAIL seq_opcode got %b want 00100", opcode); end
    checks++; if (rd !== 5'd1) begin errors++; $display("FAIL seq_rd got %0d want 1", rd); end
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL seq_instret got %0d want 3", instret); end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_imem_addr got %h want c", imem_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    pc_sel = 2'd0; inst_sel = 2'd0; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    step(); step();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (hold !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got %b want 1", i, hold); end
      step();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h want 8", i, pc); end
      checks++; if (ir !== 32'h0050_0093) begin errors++; $display("FAIL stall_ir[%0d] got %h want 00500093", i, ir); end
      checks++; if (instret !== 32'd2) begin errors++; $display("FAIL stall_instret[%0d] got %0d want 2", i, instret); end
    end
    imem_ready = 1'b1; imem_rdata = 32'h40C5_8533;
    #1;
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL release_hold got %b want 0", hold); end
    step();
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL release_pc got %h want c", pc); end
    checks++; if (ir !== 32'h40C5_8533) begin errors++; $display("FAIL release_ir got %h want 40c58533", ir); end
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL release_instret got %0d want 3", instret); end
    checks++; if ({func7, rs2, rs1, func3, rd, opcode} !== {7'h20, 5'd12, 5'd11, 3'd0, 5'd10, 5'h0C})
      begin errors++; $display("FAIL decode_fields got %h/%0d/%0d/%0d/%0d/%h want 20/12/11/0/10/0c", func7, rs2, rs1, func3, rd, opcode); end
  endtask

  task automatic test_alu_jump();
    pc_sel = 2'd1; alu_result = 32'h0000_0102; inst_sel = 2'd1; imem_ready = 1'b0;
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jump_pc got %h want 100", pc); end
    checks++; if (ir !== 32'h13) begin errors++; $display("FAIL jump_ir got %h want 13", ir); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL jump_misalign got %b want 1", misalign_err); end
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL jump_instret got %0d want 3", instret); end
    pc_sel = 2'd1; alu_result = 32'h0000_0200; inst_sel = 2'd0; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    pc_sel = 2'd0;
    step();
    checks++; if (pc !== 32'h204) begin errors++; $display("FAIL jump2_pc got %h want 204", pc); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b want 1", misalign_err); end
    do_reset();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b want 0", misalign_err); end
  endtask

  task automatic test_load_seq();
    do_reset();
    pc_sel = 2'd1; alu_result = 32'h20; inst_sel = 2'd0; imem_ready = 1'b1; imem_rdata = 32'h0030_0193;
    step();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL ld_pc0 got %h want 20", pc); end
    pc_sel = 2'd3; inst_sel = 2'd2; imem_ready = 1'b0;
    #1;
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL ld_hold_old got %b want 0", hold); end
    step();
    checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL ld_pc1 got %h want 1c", pc); end
    checks++; if (ir !== 32'h0030_0193) begin errors++; $display("FAIL ld_ir_held got %h want 00300193", ir); end
    pc_sel = 2'd0; inst_sel = 2'd1;
    step();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL ld_pc2 got %h want 20", pc); end
    checks++; if (ir !== 32'h13) begin errors++; $display("FAIL ld_ir_nop got %h want 13", ir); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL ld_instret got %0d want 1", instret); end
    pc_sel = 2'd0; inst_sel = 2'd0; imem_ready = 1'b1; imem_rdata = 32'h0070_0213;
    step();
    pc_sel = 2'd2; inst_sel = 2'd3; imem_ready = 1'b0; imem_rdata = 32'h1111_1113;
    step();
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL sel3_pc got %h want 24", pc); end
    checks++; if (ir !== 32'h0070_0213) begin errors++; $display("FAIL sel3_ir got %h want 00700213", ir); end
    checks++; if (instret !== 32'd2) begin errors++; $display("FAIL sel3_instret got %0d want 2", instret); end
  endtask

  task automatic test_wrap();
    do_reset();
    pc_sel = 2'd1; alu_result = 32'hFFFF_FFFC; inst_sel = 2'd0; imem_ready = 1'b1; imem_rdata = 32'h0;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h want fffffffc", pc); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h want 0", pc_plus4); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL wrap_illegal got %b want 1", illegal); end
    pc_sel = 2'd0; inst_sel = 2'd2;
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_p4 got %h want 0", pc); end
    pc_sel = 2'd3;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_m4 got %h want fffffffc", pc); end
  endtask

  task automatic test_rst_stall();
    do_reset();
    pc_sel = 2'd1; alu_result = 32'h40; inst_sel = 2'd0; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    pc_sel = 2'd0; imem_ready = 1'b0;
    step();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL rs_stall_pc got %h want 40", pc); end
    rst = 1'b1;
    #1;
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rs_hold_in_rst got %b want 1", hold); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rs_pc got %h want 0", pc); end
    checks++; if (ir !== 32'h13) begin errors++; $display("FAIL rs_ir got %h want 13", ir); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL rs_instret got %0d want 0", instret); end
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0090_0293;
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rs_fetch_addr got %h want 0", imem_addr); end
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL rs_post_pc got %h want 4", pc); end
    checks++; if (ir !== 32'h0090_0293) begin errors++; $display("FAIL rs_post_ir got %h want 00900293", ir); end
  endtask

  initial begin
    rst = 1'b1; pc_sel = 2'd0; inst_sel = 2'd0; alu_result = 32'd0;
    imem_rdata = 32'd0; imem_ready = 1'b1;
    test_reset();
    test_seq_fetch();
    test_stall();
    test_alu_jump();
    test_load_seq();
    test_wrap();
    test_rst_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 NOP_INST, 32'h0000_0013, instruction word injected on a flush (addi x0,x0,0).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pc_sel  in  2  next-PC select: 0=PC_P4, 1=PC_ALU, 2=PC_OLD, 3=PC_M4.
REQ-006 inst_sel  in  2  IR load select: 0=INST_MEM, 1=INST_NOP, 2=INST_OLD, 3=treated as INST_OLD.
REQ-007 alu_result  in  32  jump/branch target from ALU.
REQ-008 imem_rdata  in  32  instruction word at imem_addr.
REQ-009 imem_ready  in  1  imem_rdata valid this cycle.
REQ-010 imem_addr  out  32  fetch address, equal to pc.
REQ-011 pc  out  32  current PC.
REQ-012 pc_plus4  out  32  pc+4, for rd writeback of JAL/JALR.
REQ-013 opcode  out  5  ir[6:2].
REQ-014 func3  out  3  ir[14:12]; func7 out 7 ir[31:25]; rd/rs1/rs2 out 5 each ir[11:7]/ir[19:15]/ir[24:20].
REQ-015 ir  out  32  registered instruction word, feeds the immediate mux.
REQ-016 hold  out  1  core-wide freeze while the fetch is waiting on memory.
REQ-017 illegal  out  1  ir[1:0] != 2'b11.
REQ-018 misalign_err  out  1  sticky jump-target misalignment flag.
REQ-019 instret  out  32  count of instructions accepted from memory.

Function
REQ-020 hold SHALL be combinational: 1 iff inst_sel==INST_MEM and imem_ready==0; 0 otherwise, including while rst is high.
REQ-021 While hold==1, pc, ir, instret and misalign_err SHALL keep their values at the next edge.
REQ-022 When hold==0, pc SHALL update at the rising edge as follows: PC_P4 gives pc+4; PC_ALU gives {alu_result[31:2],2'b00}; PC_OLD gives pc; PC_M4 gives pc-4.
REQ-023 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 gives 0; 0-4 gives 32'hFFFF_FFFC.
REQ-024 When hold==0, ir SHALL update at the rising edge as follows: INST_MEM gives imem_rdata; INST_NOP gives NOP_INST; INST_OLD or 3 gives ir.
REQ-025 pc and ir SHALL update in the same edge, so that the IR always holds the word fetched from the previous pc.
REQ-026 pc_sel==PC_ALU with alu_result[1:0]!=0 and hold==0 SHALL set misalign_err at that edge; misalign_err SHALL clear only on rst.
REQ-027 instret SHALL increment by 1 at each edge where hold==0 and inst_sel==INST_MEM, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 Decode outputs, imem_addr, pc_plus4 and illegal SHALL be combinational from the registers only, with no path from an input.
REQ-029 If pc_sel and inst_sel change in the same cycle that imem_ready rises, the values sampled at the edge with hold==0 SHALL govern.

Reset
REQ-030 At the rst edge: pc=RESET_PC, ir=NOP_INST, instret=0, misalign_err=0; this SHALL take priority over hold and all selects.
REQ-031 After reset: opcode=5'b00100, illegal=0, pc_plus4=RESET_PC+4.
REQ-032 rst asserted mid-stall SHALL abandon the pending fetch; the first post-reset fetch SHALL be from RESET_PC.

Verification
REQ-033 Reset, then pc_sel=P4, inst_sel=MEM, imem_ready=1, rdata=32'h00500093 for 3 cycles: pc goes 0 to 4 to 8 to C, ir=32'h00500093, opcode=5'b00100, rd=1, instret=3.
REQ-034 Apply imem_ready=0 for 2 cycles at pc=8: hold=1 on both cycles, pc/ir/instret unchanged, then the edge after ready=1 loads ir and pc=C.
REQ-035 Apply pc_sel=ALU, alu_result=32'h0000_0102, inst_sel=NOP: pc=32'h100, ir=32'h13, misalign_err=1, and misalign_err stays 1 until rst.
REQ-036 Drive the load sequence: pc_sel=M4 with inst_sel=OLD, then P4 with NOP, starting from pc=20: pc goes 20 to 1C to 20, ir is held and then becomes 32'h13, and instret does not increment.
REQ-037 Wrap checks: pc=32'hFFFF_FFFC with P4 gives 0; pc=0 with M4 gives 32'hFFFF_FFFC; rdata=32'h0000_0000 gives illegal=1.
REQ-038 Assert rst during a stall at pc=40: the next edge gives pc=0, ir=32'h13, hold follows inst_sel/imem_ready only.
